// File: rtl/eth_top_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_top_pkg
// Purpose  : Shared types and constants for the Ethernet TX arbiter slice.
//            Holds the arbiter state encoding, the default watchdog limit
//            and the width of the watchdog stall counter.
// Revision : 1.0 - initial release
// ============================================================================
package eth_top_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2,
        ST_DRAIN = 2'd3
    } eth_tx_arb_state_e;

    // Default watchdog stall limit in clock cycles.
    localparam int unsigned c_IDLE_MAX_DEFAULT = 1024;

    // Stall counter width; covers the largest legal IdleMax (65535).
    localparam int unsigned c_STALL_W = 16;

endpackage
`default_nettype wire

// File: rtl/eth_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : eth_rr_pick
// Purpose  : Combinational round-robin selector. Returns the first asserted
//            request at or cyclically after the pointer.
// Ports    : req_i  - request vector, one bit per requester
//            ptr_i  - index where the search starts
//            idx_o  - selected index (equals ptr_i when nothing requests)
//            any_o  - high when at least one request is asserted
// Revision : 1.0 - initial release
// ============================================================================
module eth_rr_pick #(
    parameter int unsigned NumIn = 2
) (
    input  logic [NumIn-1:0]         req_i,
    input  logic [$clog2(NumIn)-1:0] ptr_i,
    output logic [$clog2(NumIn)-1:0] idx_o,
    output logic                     any_o
);

    localparam int unsigned IdxW = $clog2(NumIn);

    int cand;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx_o = ptr_i;
        cand  = 0;
        for (int k = int'(NumIn) - 1; k >= 0; k--) begin
            cand = int'(ptr_i) + k;
            if (cand >= int'(NumIn)) begin
                cand = cand - int'(NumIn);
            end
            if (req_i[IdxW'(cand)]) begin
                idx_o = IdxW'(cand);
            end
        end
    end

    assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/eth_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_arb
// Purpose  : Frame-granular round-robin arbiter merging NumIn AXI-Stream
//            requesters into one stream toward the Ethernet TX input.
//            Optional stall watchdog (compile with ETH_TX_ARB_WATCHDOG_EN)
//            aborts a frame whose owner stops sending for IdleMax cycles:
//            an error beat (tlast=1, tuser=1, data=0) terminates the frame
//            downstream and the rest of the owner's frame is discarded.
// Ports    : clk_i/rst_i           - clock, synchronous active-high reset
//            in_t*_i / in_tready_o - requester streams (packed per index)
//            out_t*_o/out_tready_i - merged stream
//            grant_o               - current (or last) owner index
//            busy_o                - high whenever not idle
//            abort_o               - one-cycle pulse on watchdog abort
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_arb
    import eth_top_pkg::*;
#(
    parameter int unsigned NumIn     = 2,
    parameter int unsigned DataWidth = 8,
    parameter int unsigned IdleMax   = c_IDLE_MAX_DEFAULT
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumIn-1:0][DataWidth-1:0]  in_tdata_i,
    input  logic [NumIn-1:0]                 in_tlast_i,
    input  logic [NumIn-1:0]                 in_tuser_i,
    input  logic [NumIn-1:0]                 in_tvalid_i,
    output logic [NumIn-1:0]                 in_tready_o,
    output logic [DataWidth-1:0]             out_tdata_o,
    output logic                             out_tlast_o,
    output logic                             out_tuser_o,
    output logic                             out_tvalid_o,
    input  logic                             out_tready_i,
    output logic [$clog2(NumIn)-1:0]         grant_o,
    output logic                             busy_o,
    output logic                             abort_o
);

    localparam int unsigned IdxW = $clog2(NumIn);

    eth_tx_arb_state_e state_q;
    logic [IdxW-1:0]   grant_q;
    logic [IdxW-1:0]   ptr_q;
    logic [IdxW-1:0]   ptr_d;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_any;
    logic              sel_valid;
    logic              sel_last;

    eth_rr_pick #(
        .NumIn (NumIn)
    ) u_pick (
        .req_i (in_tvalid_i),
        .ptr_i (ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign sel_valid = in_tvalid_i[grant_q];
    assign sel_last  = in_tlast_i[grant_q];

    // Pointer moves past the owner that just finished its frame.
    assign ptr_d = (grant_q == IdxW'(NumIn - 1)) ? '0 : grant_q + IdxW'(1);

`ifdef ETH_TX_ARB_WATCHDOG_EN
    localparam logic [c_STALL_W-1:0] c_STALL_LAST = c_STALL_W'(IdleMax - 1);

    logic [c_STALL_W-1:0] stall_q;
    logic                 abort_q;
`else
    // IdleMax has no effect without the watchdog.
    logic unused_cfg;
    assign unused_cfg = (IdleMax == 0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
            stall_q <= '0;
            abort_q <= 1'b0;
`endif
        end else begin
`ifdef ETH_TX_ARB_WATCHDOG_EN
            abort_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
`ifdef ETH_TX_ARB_WATCHDOG_EN
                    stall_q <= '0;
`endif
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (sel_valid && sel_last && out_tready_i) begin
                        ptr_q   <= ptr_d;
                        state_q <= ST_IDLE;
                    end
`ifdef ETH_TX_ARB_WATCHDOG_EN
                    // Counter holds the number of stalled cycles seen so far;
                    // the stall that would make it IdleMax triggers the abort.
                    if (sel_valid) begin
                        stall_q <= '0;
                    end else if (stall_q >= c_STALL_LAST) begin
                        stall_q <= '0;
                        abort_q <= 1'b1;
                        state_q <= ST_ABORT;
                    end else begin
                        stall_q <= stall_q + c_STALL_W'(1);
                    end
`endif
                end
`ifdef ETH_TX_ARB_WATCHDOG_EN
                ST_ABORT: begin
                    if (out_tready_i) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (sel_valid && sel_last) begin
                        ptr_q   <= ptr_d;
                        state_q <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output steering. Everything is forced low while reset is asserted so a
    // frame in flight is dropped in the same cycle reset arrives.
    always_comb begin
        out_tdata_o  = '0;
        out_tlast_o  = 1'b0;
        out_tuser_o  = 1'b0;
        out_tvalid_o = 1'b0;
        in_tready_o  = '0;
        case (state_q)
            ST_GRANT: begin
                out_tdata_o           = in_tdata_i[grant_q];
                out_tlast_o           = in_tlast_i[grant_q];
                out_tuser_o           = in_tuser_i[grant_q];
                out_tvalid_o          = sel_valid;
                in_tready_o[grant_q]  = out_tready_i;
            end
`ifdef ETH_TX_ARB_WATCHDOG_EN
            ST_ABORT: begin
                out_tlast_o  = 1'b1;
                out_tuser_o  = 1'b1;
                out_tvalid_o = 1'b1;
            end
            ST_DRAIN: begin
                in_tready_o[grant_q] = 1'b1;
            end
`endif
            default: begin
                out_tvalid_o = 1'b0;
            end
        endcase
        if (rst_i) begin
            out_tdata_o  = '0;
            out_tlast_o  = 1'b0;
            out_tuser_o  = 1'b0;
            out_tvalid_o = 1'b0;
            in_tready_o  = '0;
        end
    end

    assign grant_o = rst_i ? '0 : grant_q;
    assign busy_o  = ~rst_i & (state_q != ST_IDLE);
`ifdef ETH_TX_ARB_WATCHDOG_EN
    assign abort_o = ~rst_i & abort_q;
`else
    assign abort_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_arb
// Purpose  : Self-checking bench for eth_tx_arb (NumIn=2, DataWidth=8,
//            IdleMax=4). Per-port beat queues drive the requesters; each
//            test pushes its hand-computed output beats into a scoreboard
//            that a separate monitor pops on every output handshake.
//            The gap field is the expected number of cycles since the
//            previous output handshake (or since the test start marker).
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_tx_arb;

    localparam int NUM_IN   = 2;
    localparam int DW       = 8;
    localparam int IDLE_MAX = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_IN-1:0][DW-1:0]  in_tdata;
    logic [NUM_IN-1:0]          in_tlast;
    logic [NUM_IN-1:0]          in_tuser;
    logic [NUM_IN-1:0]          in_tvalid;
    logic [NUM_IN-1:0]          in_tready;
    logic [DW-1:0]              out_tdata;
    logic                       out_tlast;
    logic                       out_tuser;
    logic                       out_tvalid;
    logic                       out_tready;
    logic [0:0]                 grant;
    logic                       busy;
    logic                       abort;

    always #5 clk = ~clk;

    eth_tx_arb #(
        .NumIn     (NUM_IN),
        .DataWidth (DW),
        .IdleMax   (IDLE_MAX)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_tdata_i   (in_tdata),
        .in_tlast_i   (in_tlast),
        .in_tuser_i   (in_tuser),
        .in_tvalid_i  (in_tvalid),
        .in_tready_o  (in_tready),
        .out_tdata_o  (out_tdata),
        .out_tlast_o  (out_tlast),
        .out_tuser_o  (out_tuser),
        .out_tvalid_o (out_tvalid),
        .out_tready_i (out_tready),
        .grant_o      (grant),
        .busy_o       (busy),
        .abort_o      (abort)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        int         stall;
    } beat_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic       g;
        logic       ab;
        int         gap;
    } exp_t;

    beat_t txq0[$];
    beat_t txq1[$];
    exp_t  exp_q[$];
    int    wcnt [2];
    int    err        = 0;
    int    total      = 0;
    int    nc         = 0;
    int    last_hs    = 0;
    int    abort_seen = 0;

    // Present the head of each port queue (after its idle lead-in expires).
    function automatic void apply();
        in_tvalid = '0;
        in_tdata  = '0;
        in_tlast  = '0;
        in_tuser  = '0;
        if (txq0.size() != 0) begin
            in_tdata[0]  = txq0[0].data;
            in_tlast[0]  = txq0[0].last;
            in_tuser[0]  = txq0[0].user;
            in_tvalid[0] = (wcnt[0] == 0);
        end
        if (txq1.size() != 0) begin
            in_tdata[1]  = txq1[0].data;
            in_tlast[1]  = txq1[0].last;
            in_tuser[1]  = txq1[0].user;
            in_tvalid[1] = (wcnt[1] == 0);
        end
    endfunction

    // stall = cycles tvalid stays low before this beat is offered.
    function automatic void push(int p, logic [7:0] d, logic l, logic u, int st);
        beat_t b;
        b.data  = d;
        b.last  = l;
        b.user  = u;
        b.stall = st;
        if (p == 0) begin
            if (txq0.size() == 0) wcnt[0] = st;
            txq0.push_back(b);
        end else begin
            if (txq1.size() == 0) wcnt[1] = st;
            txq1.push_back(b);
        end
    endfunction

    function automatic void expect_beat(logic [7:0] d, logic l, logic u, logic g, logic ab, int gap);
        exp_t e;
        e.data = d;
        e.last = l;
        e.user = u;
        e.g    = g;
        e.ab   = ab;
        e.gap  = gap;
        exp_q.push_back(e);
    endfunction

    function automatic void check_zero(string name);
        logic [15:0] v;
        v = {out_tvalid, out_tlast, out_tuser, out_tdata, in_tready, grant, busy, abort};
        total++;
        if (v != 16'h0000) begin
            err++;
            $display("FAIL %s: outputs=%h required 0000", name, v);
        end
    endfunction

    task automatic wait_drain(string name, int max);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(posedge clk); #2;
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            err++;
            $display("FAIL %s: %0d beats outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Requester driver: consume a beat when it handshook on the last edge.
    initial begin : drv
        logic [1:0] hs;
        forever begin
            @(negedge clk);
            hs = in_tvalid & in_tready;
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (wcnt[p] > 0) wcnt[p]--;
            end
            if (hs[0] && txq0.size() != 0) begin
                txq0.delete(0);
                if (txq0.size() != 0) wcnt[0] = txq0[0].stall;
            end
            if (hs[1] && txq1.size() != 0) begin
                txq1.delete(0);
                if (txq1.size() != 0) wcnt[1] = txq1[0].stall;
            end
            apply();
        end
    end

    // Monitor: compare every accepted output beat with the scoreboard head.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            nc++;
            if (abort) abort_seen++;
            if (out_tvalid && out_tready) begin
                total++;
                if (exp_q.size() == 0) begin
                    err++;
                    $display("FAIL beat_unexpected: got data=%h last=%b user=%b grant=%0d, required no beat",
                             out_tdata, out_tlast, out_tuser, grant);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_tdata, out_tlast, out_tuser, grant, abort} !== {e.data, e.last, e.user, e.g, e.ab}) begin
                        err++;
                        $display("FAIL beat: got data=%h last=%b user=%b grant=%0d abort=%b, required data=%h last=%b user=%b grant=%0d abort=%b",
                                 out_tdata, out_tlast, out_tuser, grant, abort, e.data, e.last, e.user, e.g, e.ab);
                    end
                    if (e.gap >= 0) begin
                        total++;
                        if (nc - last_hs != e.gap) begin
                            err++;
                            $display("FAIL beat_gap data=%h: got %0d cycles, required %0d", e.data, nc - last_hs, e.gap);
                        end
                    end
                end
                last_hs = nc;
            end
        end
    end

    initial begin : main
        int n;
        out_tready = 1'b1;
        wcnt[0]    = 0;
        wcnt[1]    = 0;
        rst        = 1'b1;
        apply();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset_hold");
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset_release");
        @(posedge clk); #2;

        // Both ports valid together: port 0 frame, one bubble, port 1 frame.
        push(0, 8'h01, 1'b0, 1'b0, 0); push(0, 8'h02, 1'b0, 1'b0, 0); push(0, 8'h03, 1'b1, 1'b0, 0);
        push(1, 8'h11, 1'b0, 1'b0, 0); push(1, 8'h12, 1'b0, 1'b0, 0); push(1, 8'h13, 1'b1, 1'b0, 0);
        expect_beat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        expect_beat(8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        expect_beat(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        expect_beat(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        expect_beat(8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        expect_beat(8'h13, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        last_hs = nc + 1;
        apply();
        wait_drain("two_port_rr", 50);

        // Port 1 alone, back-to-back frames incl. a single-beat frame.
        push(1, 8'h21, 1'b0, 1'b0, 0); push(1, 8'h22, 1'b1, 1'b0, 0);
        push(1, 8'h23, 1'b0, 1'b0, 0); push(1, 8'h24, 1'b1, 1'b0, 0);
        push(1, 8'h25, 1'b1, 1'b0, 0);
        expect_beat(8'h21, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        expect_beat(8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        expect_beat(8'h23, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        expect_beat(8'h24, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        expect_beat(8'h25, 1'b1, 1'b0, 1'b1, 1'b0, 2);
        last_hs = nc + 1;
        apply();
        wait_drain("single_port_b2b", 50);

        // Downstream ready toggling; port 1 must wait for port 0's tlast.
        push(0, 8'h31, 1'b0, 1'b0, 0); push(0, 8'h32, 1'b0, 1'b0, 0);
        push(0, 8'h33, 1'b0, 1'b1, 0); push(0, 8'h34, 1'b1, 1'b0, 0);
        push(1, 8'h41, 1'b0, 1'b0, 0); push(1, 8'h42, 1'b1, 1'b0, 0);
        expect_beat(8'h31, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        expect_beat(8'h32, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        expect_beat(8'h33, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        expect_beat(8'h34, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        expect_beat(8'h41, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        expect_beat(8'h42, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        apply();
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #2;
            out_tready = ~out_tready;
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            err++;
            $display("FAIL ready_toggle: %0d beats outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        out_tready = 1'b1;
        @(posedge clk); #2;

`ifdef ETH_TX_ARB_WATCHDOG_EN
        // Port 0 stalls after beat 2: abort beat, drain, then port 1.
        push(0, 8'h51, 1'b0, 1'b0, 0); push(0, 8'h52, 1'b0, 1'b0, 0);
        push(0, 8'h53, 1'b0, 1'b0, 10); push(0, 8'h54, 1'b1, 1'b0, 0);
        push(1, 8'h61, 1'b0, 1'b0, 0); push(1, 8'h62, 1'b1, 1'b0, 0);
        expect_beat(8'h51, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        expect_beat(8'h52, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        expect_beat(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 5);
        expect_beat(8'h61, 1'b0, 1'b0, 1'b1, 1'b0, 9);
        expect_beat(8'h62, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        last_hs    = nc + 1;
        abort_seen = 0;
        apply();
        wait_drain("watchdog_abort", 100);
        total++;
        if (abort_seen != 1) begin
            err++;
            $display("FAIL abort_pulse: got %0d cycles, required 1", abort_seen);
        end
        total++;
        if (txq0.size() != 0) begin
            err++;
            $display("FAIL drain_consumed: got %0d beats left, required 0", txq0.size());
        end
`else
        // Long mid-frame stall with no watchdog: ownership kept.
        push(0, 8'h71, 1'b0, 1'b0, 0); push(0, 8'h72, 1'b0, 1'b0, 0);
        push(0, 8'h73, 1'b1, 1'b0, 5000);
        push(1, 8'h81, 1'b1, 1'b0, 0);
        expect_beat(8'h71, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        expect_beat(8'h72, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        expect_beat(8'h73, 1'b1, 1'b0, 1'b0, 1'b0, 5001);
        expect_beat(8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 2);
        last_hs    = nc + 1;
        abort_seen = 0;
        apply();
        wait_drain("long_stall", 6000);
        total++;
        if (abort_seen != 0) begin
            err++;
            $display("FAIL no_abort: got %0d abort cycles, required 0", abort_seen);
        end
`endif

        // Move pointer to 1, then reset during beat 2 of a port 1 frame.
        push(0, 8'h90, 1'b1, 1'b0, 0);
        expect_beat(8'h90, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        last_hs = nc + 1;
        apply();
        wait_drain("ptr_advance", 20);
        push(1, 8'h91, 1'b0, 1'b0, 0); push(1, 8'h92, 1'b0, 1'b0, 0); push(1, 8'h93, 1'b1, 1'b0, 0);
        expect_beat(8'h91, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        last_hs = nc + 1;
        apply();
        wait_drain("pre_reset_beat", 20);
        rst = 1'b1;
        @(negedge clk);
        check_zero("reset_midframe");
        @(posedge clk); #2;
        rst = 1'b0;
        txq0.delete();
        txq1.delete();
        wcnt[0] = 0;
        wcnt[1] = 0;
        apply();
        @(negedge clk);
        check_zero("reset_midframe_after");
        @(posedge clk); #2;
        push(0, 8'hB1, 1'b1, 1'b0, 0);
        push(1, 8'hA1, 1'b0, 1'b0, 0); push(1, 8'hA2, 1'b1, 1'b0, 0);
        expect_beat(8'hB1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        expect_beat(8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        expect_beat(8'hA2, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        last_hs = nc + 1;
        apply();
        wait_drain("post_reset", 50);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", err, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_tx_arb.md
ETH_TX_ARB -- requirements
Module: eth_tx_arb

Interface
REQ-001 SHALL have parameter NumIn, default 2, number of AXI-Stream TX requesters (legal 2..8).
REQ-002 SHALL have parameter DataWidth, default 8, tdata width per beat.
REQ-003 SHALL have parameter IdleMax, default 1024, watchdog stall limit in cycles (legal 2..65535).
REQ-004 SHALL have port clk_i  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_tdata_i  input  NumIn x DataWidth  requester beat data.
REQ-007 SHALL have ports in_tlast_i, in_tuser_i, in_tvalid_i  input  NumIn each  per-requester last, error flag, valid.
REQ-008 SHALL have port in_tready_o  output  NumIn  per-requester ready.
REQ-009 SHALL have ports out_tdata_o (DataWidth), out_tlast_o, out_tuser_o, out_tvalid_o  output  merged stream toward the Ethernet TX input.
REQ-010 SHALL have port out_tready_i  input  1  downstream ready.
REQ-011 SHALL have port grant_o  output  clog2(NumIn)  index of current owner; busy_o  output  1  high outside IDLE.
REQ-012 SHALL have port abort_o  output  1  one-cycle pulse when a frame is aborted by the watchdog.

Function
REQ-013 SHALL arbitrate at frame granularity: once granted, a requester owns the output until its tlast beat handshakes.
REQ-014 SHALL implement states IDLE, GRANT, ABORT, DRAIN.
REQ-015 In IDLE SHALL drive out_tvalid_o=0 and all in_tready_o=0; if any in_tvalid_i high, register grant and enter GRANT next cycle.
REQ-016 Grant selection SHALL be round-robin: first valid index at or cyclically after pointer ptr; reset ptr=0.
REQ-017 In GRANT SHALL pass in[g] data/last/user/valid combinationally to out, in_tready_o[g]=out_tready_i, other readies 0.
REQ-018 On handshake of beat with tlast in GRANT SHALL set ptr=(g+1) mod NumIn and return to IDLE; exactly one bubble cycle between frames.
REQ-019 Requesters deasserting tvalid mid-frame SHALL keep ownership (no re-arbitration before tlast).
REQ-020 In GRANT a stall counter SHALL count consecutive cycles with in_tvalid_i[g]=0, clear on any valid cycle, saturate at IdleMax.
REQ-021 On counter reaching IdleMax SHALL enter ABORT: out_tvalid_o=1, out_tlast_o=1, out_tuser_o=1, out_tdata_o=0, in_tready_o all 0; abort_o pulses on entry.
REQ-022 ABORT SHALL hold until out_tready_i=1, then enter DRAIN.
REQ-023 DRAIN SHALL hold in_tready_o[g]=1, out_tvalid_o=0, discard beats until a tlast beat of g accepted, then ptr=(g+1) mod NumIn, IDLE.
REQ-024 Back-to-back frames from a single requester SHALL each be granted, with one IDLE cycle between.
REQ-025 grant_o SHALL hold last owner while in IDLE.

Reset
REQ-026 On rst_i=1 at a clock edge SHALL enter IDLE, ptr=0, grant_o=0, stall counter=0, abort_o=0, busy_o=0.
REQ-027 Reset mid-frame SHALL drop ownership immediately; no tlast synthesised; upstream resets in same domain.
REQ-028 All outputs SHALL be 0 during and one cycle after reset.

Configuration
REQ-029 Macro ETH_TX_ARB_WATCHDOG_EN defined SHALL compile in stall counter, ABORT, DRAIN (REQ-020..023).
REQ-030 Macro undefined SHALL omit counter and states; abort_o tied 0; GRANT waits indefinitely; IdleMax ignored.

Structure
REQ-031 State enum eth_tx_arb_state_e and default IdleMax constant SHALL live in eth_top_pkg.
REQ-032 Round-robin index selection SHALL be a combinational sub-module eth_rr_pick (inputs req vector, ptr; outputs idx, any).

Verification
REQ-033 NumIn=2, both valid at cycle 0, 3-beat frames, out_tready=1 -> port 0 frame beats cycles 1-3, IDLE cycle 4, port 1 beats cycles 5-7.
REQ-034 Port 1 continuously valid, port 0 idle -> consecutive port-1 frames, each separated by exactly one out_tvalid_o=0 cycle.
REQ-035 Port 0 frame with out_tready toggling 1/0 -> every beat appears once in order, data unchanged, port 1 never granted before port 0 tlast.
REQ-036 Watchdog on, IdleMax=4, port 0 stops after beat 2 -> abort_o pulse, out beat tlast=1 tuser=1 data=0; remaining port-0 beats drained; port 1 then granted.
REQ-037 rst_i asserted during beat 2 of a frame -> next cycle all outputs 0, state IDLE, ptr=0, new frame from port 1 granted normally.
REQ-038 Watchdog off, port 0 stalls 5000 cycles mid-frame -> no abort, ownership kept, frame completes on resume.
